// File: rtl/bldc_pkg.sv
// Shared types, hall sequence and lookup helpers for the six-step BLDC commutator.
// Commutation table returns forward drive; rev swaps forward/reverse current.
package bldc_pkg;

  typedef enum logic [1:0] {
    HIGH_Z        = 2'd0,
    rev_curr      = 2'd1,
    for_curr      = 2'd2,
    regen_braking = 2'd3
  } drive_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } comm_state_t;

  typedef struct packed {
    drive_t grn;
    drive_t ylw;
    drive_t blu;
  } phase_sel_t;

  localparam logic [2:0] HALL_SEQ [0:5] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

  // Unknown codes (000/111) map to 000 so they never match a neighbour.
  function automatic logic [2:0] hall_next(input logic [2:0] code);
    logic [2:0] r;
    r = 3'b000;
    for (logic [2:0] i = 3'd0; i < 3'd6; i = i + 3'd1)
      if (HALL_SEQ[i] == code) r = HALL_SEQ[(i == 3'd5) ? 3'd0 : i + 3'd1];
    return r;
  endfunction

  function automatic logic [2:0] hall_prev(input logic [2:0] code);
    logic [2:0] r;
    r = 3'b000;
    for (logic [2:0] i = 3'd0; i < 3'd6; i = i + 3'd1)
      if (HALL_SEQ[i] == code) r = HALL_SEQ[(i == 3'd0) ? 3'd5 : i - 3'd1];
    return r;
  endfunction

  function automatic phase_sel_t comm_lookup(input logic [2:0] code, input logic rev);
    phase_sel_t s;
    drive_t     f;
    drive_t     r;
    f = rev ? rev_curr : for_curr;
    r = rev ? for_curr : rev_curr;
    s = '{HIGH_Z, HIGH_Z, HIGH_Z};
    case (code)
      3'b101:  s = '{f, r, HIGH_Z};
      3'b100:  s = '{f, HIGH_Z, r};
      3'b110:  s = '{HIGH_Z, f, r};
      3'b010:  s = '{r, f, HIGH_Z};
      3'b011:  s = '{r, HIGH_Z, f};
      3'b001:  s = '{HIGH_Z, r, f};
      default: s = '{HIGH_Z, HIGH_Z, HIGH_Z};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hall_filter.sv
// Hall bus synchronizer followed by a glitch filter that requires FILT_CYCLES
// consecutive identical synchronized samples before reporting the code as stable.
module hall_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] hall_in,
  output logic [2:0] code,
  output logic       stable
);
  localparam int CNT_W = $clog2(FILT_CYCLES + 1);

  logic [2:0]       r_sync [SYNC_STAGES];
  logic [2:0]       w_sync;
  logic [2:0]       r_cand;
  logic [CNT_W-1:0] r_cnt;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clk) begin
        if (rst) r_sync[gi] <= 3'b000;
        else if (gi == 0) r_sync[gi] <= hall_in;
        else r_sync[gi] <= r_sync[(gi == 0) ? 0 : gi - 1];
      end
    end
  endgenerate

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand <= 3'b000;
      r_cnt  <= '0;
    end else if (w_sync != r_cand) begin
      r_cand <= w_sync;
      r_cnt  <= '0;
    end else if (r_cnt != CNT_W'(FILT_CYCLES)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A sample disagreeing with the candidate this cycle cancels stability immediately.
  assign code   = r_cand;
  assign stable = (r_cnt == CNT_W'(FILT_CYCLES)) && (w_sync == r_cand);

endmodule

// File: rtl/brushless_commutator.sv
// Six-step BLDC commutation controller with hall filtering, sequence fault and brake/coast.
// Optional duty slew limiter enabled by defining BRUSHLESS_SLEW_EN.
module brushless_commutator
  import bldc_pkg::*;
#(
  parameter int DRV_W       = 12,
  parameter int DUTY_W      = 11,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int FAULT_LIMIT = 3,
  parameter int SLEW_STEP   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hallGrn,
  input  logic              hallYlw,
  input  logic              hallBlu,
  input  logic              brake_n,
  input  logic              coast,
  input  logic              reverse,
  input  logic              PWM_synch,
  input  logic              fault_clr,
  input  logic [DRV_W-1:0]  drv_mag,
  output logic [1:0]        selGrn,
  output logic [1:0]        selYlw,
  output logic [1:0]        selBlu,
  output logic [DUTY_W-1:0] duty,
  output logic              fault,
  output logic              comm_tick
);
  localparam int ERR_W = $clog2(FAULT_LIMIT + 1);
  localparam logic [DUTY_W-1:0] DUTY_MID   = DUTY_W'(1) << (DUTY_W - 1);
  localparam logic [DUTY_W-1:0] DUTY_BRAKE = DUTY_W'(3) << (DUTY_W - 2);

  logic [2:0]        w_code;
  logic              w_stable;
  comm_state_t       r_state, w_state_next;
  logic [2:0]        r_acc, w_acc_next;
  logic [ERR_W-1:0]  r_err_cnt, w_err_next;
  logic              w_tick_next, r_tick_pend, r_tick;
  logic              w_eval, w_valid, w_adj;
  phase_sel_t        r_sel, w_sel_next;
  logic [DUTY_W-1:0] r_duty, w_target, w_duty_next, w_drive_duty;

  hall_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_CYCLES(FILT_CYCLES)
  ) u_hall_filter (
    .clk    (clk),
    .rst    (rst),
    .hall_in({hallGrn, hallYlw, hallBlu}),
    .code   (w_code),
    .stable (w_stable)
  );

  // IDLE re-evaluates the held code so a fault clear can restart without a hall edge.
  assign w_eval  = PWM_synch && w_stable && ((w_code != r_acc) || (r_state == IDLE));
  assign w_valid = (w_code != 3'b000) && (w_code != 3'b111);
  assign w_adj   = w_valid && ((w_code == hall_next(r_acc)) || (w_code == hall_prev(r_acc)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= 3'b000;
      r_err_cnt   <= '0;
      r_tick_pend <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_acc       <= w_acc_next;
      r_err_cnt   <= w_err_next;
      r_tick_pend <= w_tick_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_err_next   = r_err_cnt;
    w_tick_next  = 1'b0;
    if (w_eval) w_acc_next = w_code;
    case (r_state)
      IDLE: if (w_eval && w_valid) w_state_next = RUN;
      RUN: begin
        if (w_eval) begin
          if (w_adj) begin
            w_err_next  = '0;
            w_tick_next = 1'b1;
          end else begin
            w_err_next = r_err_cnt + 1'b1;
            if (r_err_cnt == ERR_W'(FAULT_LIMIT - 1)) w_state_next = FAULT;
          end
        end
      end
      FAULT: begin
        if (fault_clr) begin
          w_state_next = IDLE;
          w_err_next   = '0;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_sel_next = comm_lookup(r_acc, reverse);
    if (r_state == FAULT)                w_sel_next = '{HIGH_Z, HIGH_Z, HIGH_Z};
    else if (!brake_n)                   w_sel_next = '{regen_braking, regen_braking, regen_braking};
    else if (coast || (r_state == IDLE)) w_sel_next = '{HIGH_Z, HIGH_Z, HIGH_Z};
  end

  // Tick is delayed one clock so it lines up with the sel change it announces.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel  <= '{HIGH_Z, HIGH_Z, HIGH_Z};
      r_tick <= 1'b0;
    end else begin
      r_sel  <= w_sel_next;
      r_tick <= r_tick_pend;
    end
  end

  assign w_drive_duty = {1'b0, drv_mag[DRV_W-1 -: DUTY_W-1]} + DUTY_MID;

  always_comb begin
    w_target = w_drive_duty;
    if ((r_state == FAULT) || (brake_n && coast)) w_target = DUTY_MID;
    else if (!brake_n)                            w_target = DUTY_BRAKE;
  end

`ifdef BRUSHLESS_SLEW_EN
  localparam logic [DUTY_W-1:0] SLEW_DELTA = DUTY_W'(SLEW_STEP);
  always_comb begin
    w_duty_next = w_target;
    if (w_target > r_duty) begin
      if ((w_target - r_duty) > SLEW_DELTA) w_duty_next = r_duty + SLEW_DELTA;
    end else if ((r_duty - w_target) > SLEW_DELTA) begin
      w_duty_next = r_duty - SLEW_DELTA;
    end
  end
`else
  logic [31:0] w_unused_slew;
  assign w_unused_slew = 32'(SLEW_STEP);
  assign w_duty_next   = w_target;
`endif

  generate
    if (DRV_W > DUTY_W - 1) begin : g_unused_lsb
      logic w_unused_drv;
      assign w_unused_drv = ^drv_mag[DRV_W-DUTY_W:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) r_duty <= DUTY_MID;
    else if (PWM_synch) r_duty <= w_duty_next;
  end

  assign selGrn    = r_sel.grn;
  assign selYlw    = r_sel.ylw;
  assign selBlu    = r_sel.blu;
  assign duty      = r_duty;
  assign fault     = (r_state == FAULT);
  assign comm_tick = r_tick;

endmodule

// File: doc/brushless_commutator.md
# brushless_commutator

Parametrised six-step commutation controller for the e-bike BLDC motor. Sits between the hall-sensor pins and the three-phase gate-drive PWM stage, like the first-generation commutator. Adds over that generation: configurable widths and synchronizer depth, a hall glitch filter, reverse drive, coast mode, hall-sequence checking with latched fault, and an optional duty slew limiter. All commutation changes are aligned to PWM_synch.

## Interface
Parameters:
- DRV_W, 12, width of drv_mag; must satisfy DRV_W >= DUTY_W-1
- DUTY_W, 11, width of duty
- SYNC_STAGES, 2, hall metastability flops (>=2)
- FILT_CYCLES, 4, consecutive identical synchronized samples required to accept a hall code (>=1)
- FAULT_LIMIT, 3, sequence errors before fault latches (>=1)
- SLEW_STEP, 16, maximum duty change per PWM_synch; used only with slew enabled

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- hallGrn, hallYlw, hallBlu  in  1 each  asynchronous hall inputs
- brake_n  in  1  active-low regenerative brake request
- coast  in  1  all phases high-Z, duty midscale
- reverse  in  1  swap forward/reverse current on every driven phase
- PWM_synch  in  1  one-cycle pulse at PWM period boundary
- fault_clr  in  1  clears latched fault
- drv_mag  in  DRV_W  drive magnitude
- selGrn, selYlw, selBlu  out  2 each  phase drive select: 0 HIGH_Z, 1 rev_curr, 2 for_curr, 3 regen_braking
- duty  out  DUTY_W  PWM duty
- fault  out  1  latched hall fault
- comm_tick  out  1  one-cycle pulse per accepted valid commutation step

## Operation
- Hall path: SYNC_STAGES flops per input, then the filter. The filter holds a candidate code and a counter. It resets the counter when the synchronized code differs from the candidate. It marks the code stable once the code has matched for FILT_CYCLES clocks.
- On PWM_synch, a stable code that differs from the accepted code is evaluated:
  - It is then loaded into the accepted code.
  - Otherwise the accepted code holds.
- Forward sequence: 101→100→110→010→011→001→101.
- A step is valid if the new code is the successor or predecessor of the old code in the sequence.
- State machine:
  - IDLE (reset): the first valid code (not 000/111) accepted → RUN. This step does no adjacency check and gives no comm_tick.
  - RUN, valid adjacent step: err_cnt cleared, comm_tick=1.
  - RUN, code 000/111 or a non-adjacent code: err_cnt+1. When err_cnt reaches FAULT_LIMIT → FAULT.
  - FAULT: fault=1, errors ignored. fault_clr → IDLE with err_cnt=0.
- Commutation table, forward (Grn/Ylw/Blu):
  - 101: F/R/Z
  - 100: F/Z/R
  - 110: Z/F/R
  - 010: R/F/Z
  - 011: R/Z/F
  - 001: Z/R/F
  - 000, 111, and IDLE: all Z.
- reverse=1 exchanges F and R in the table.
- Output priority: FAULT (all Z) > brake_n=0 (all regen_braking) > coast (all Z) > table.
- Duty target:
  - FAULT or coast: midscale, 1<<(DUTY_W-1).
  - Brake: 3<<(DUTY_W-2).
  - Otherwise: drv_mag[DRV_W-1 -: DUTY_W-1] + midscale. The add cannot overflow.

## Timing
- Reset values: sel*=0, duty=midscale, fault=0, comm_tick=0, err_cnt=0, state IDLE, filter candidate=000 with counter 0.
- Hall edge to accepted code: SYNC_STAGES + FILT_CYCLES clocks minimum, then wait for the next PWM_synch.
- sel* are registered. They update on the clock after the accepted code, the state, brake_n, coast or reverse change.
- comm_tick is asserted in the same cycle the sel* change it caused.
- duty updates only on PWM_synch, one clock later.
- PWM_synch coinciding with a filter reset: the code is not stable, so nothing is accepted.
- rst mid-operation: everything returns to reset values on the next edge, including a latched fault.
- fault_clr in the same cycle as the fault-causing step: the fault latches. fault_clr acts only in FAULT.

## Configuration
- Macro: BRUSHLESS_SLEW_EN.
- Defined: on each PWM_synch, duty moves toward the target by min(|target−duty|, SLEW_STEP). Brake, coast and FAULT targets are slewed too.
- Not defined: duty loads the target directly on PWM_synch. SLEW_STEP is unused.

## Structure
- Shared package bldc_pkg holds:
  - drive_t enum {HIGH_Z, rev_curr, for_curr, regen_braking}
  - comm_state_t {IDLE, RUN, FAULT}
  - the six-entry forward hall sequence constant
  - next/prev lookup functions
- Sub-module hall_filter: synchronizer plus glitch filter for the 3-bit hall bus. Parameters SYNC_STAGES and FILT_CYCLES. Outputs code[2:0] and stable.

## Test plan
- Reset, then hall=101 held, PWM_synch every 32 clocks → IDLE→RUN, sel=2/1/0, no comm_tick, duty=0x400 + drv_mag[11:2].
- Full forward rotation, reverse=1 → sel follows the table with F/R swapped. Six comm_ticks, one per step, each on a PWM_synch boundary.
- Hall 1-clock glitch 100→000→100 with FILT_CYCLES=4 → code never accepted, no error, sel unchanged.
- Three non-adjacent jumps (101→110→001→100) → fault=1 after the third, sel all 0, duty=0x400. fault_clr → IDLE, fault=0.
- brake_n=0 while in RUN → sel=3/3/3 one clock later, duty=0x600 at the next PWM_synch. With coast=1 at the same time, brake still wins.
- With BRUSHLESS_SLEW_EN and SLEW_STEP=16, drv_mag 0→0xFFC → duty rises by 16 per PWM_synch from 0x400 until it reaches 0x7FF.
